// File: rtl/aes_pkg.sv
// Shared AES definitions for the round sequencer: FSM states, datapath op codes,
// the forward S-box and the key-schedule round constants.
package aes_pkg;

    typedef enum logic [2:0] {
        st_idle  = 3'd0,
        st_init  = 3'd1,
        st_round = 3'd2,
        st_final = 3'd3,
        st_done  = 3'd4
    } state_e;

    localparam logic [1:0] mode_ark   = 2'd0;
    localparam logic [1:0] mode_round = 2'd1;
    localparam logic [1:0] mode_final = 2'd2;
    localparam logic [1:0] mode_idle  = 2'd3;

    localparam int last_round = 10;

    // Entry 0 occupies the most significant byte.
    localparam logic [2047:0] sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return sbox_table[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives round key r from round key r-1 and rcon(r).
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);

    logic [31:0] w3_rot;
    logic [31:0] w3_sub;
    logic [31:0] temp;
    logic [31:0] w0, w1, w2, w3;

    assign w3_rot = {rk[23:0], rk[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            assign w3_sub[gi*8 +: 8] = sbox(w3_rot[gi*8 +: 8]);
        end
    endgenerate

    assign temp = w3_sub ^ {rcon, 24'h000000};
    assign w0   = rk[127:96] ^ temp;
    assign w1   = rk[95:64]  ^ w0;
    assign w2   = rk[63:32]  ^ w1;
    assign w3   = rk[31:0]   ^ w2;

    assign rk_next = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 encryption sequencer driving an external round datapath; each op is held
// round_cycles_p cycles. Define AES_SEQ_ABORT_EN to add the abort_i port.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int round_cycles_p = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    input  logic [127:0] key_i,
    output logic [127:0] dp_state_o,
    output logic [127:0] dp_key_o,
    output logic [1:0]   dp_mode_o,
    input  logic [127:0] dp_result_i,
    output logic         v_o,
    output logic [127:0] data_o,
`ifdef AES_SEQ_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         yumi_i
);

    localparam logic [1:0] hold_last = 2'(round_cycles_p - 1);

    state_e       fsm_reg, fsm_next;
    logic [127:0] blk_reg;
    logic [127:0] key_reg;
    logic [127:0] key_next;
    logic [3:0]   round_reg;
    logic [1:0]   hold_reg;
    logic         busy;
    logic         capture;
    logic         abort_req;

    assign busy    = (fsm_reg == st_init) || (fsm_reg == st_round) || (fsm_reg == st_final);
    assign capture = busy && (hold_reg == hold_last);

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort_i && busy;
`else
    assign abort_req = 1'b0;
`endif

    // The key for round r+1 is prepared while round r is being held.
    aes_key_step u_key_step (
        .rk      (key_reg),
        .rcon    (rcon(4'(round_reg + 4'd1))),
        .rk_next (key_next)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_reg <= st_idle;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blk_reg   <= '0;
            key_reg   <= '0;
            round_reg <= '0;
            hold_reg  <= '0;
        end else if (fsm_reg == st_idle) begin
            if (v_i) begin
                blk_reg   <= data_i;
                key_reg   <= key_i;
                round_reg <= '0;
                hold_reg  <= '0;
            end
        end else if (busy) begin
            if (abort_req) begin
                hold_reg <= '0;
            end else if (capture) begin
                hold_reg <= '0;
                blk_reg  <= dp_result_i;
                if (fsm_reg != st_final) begin
                    key_reg   <= key_next;
                    round_reg <= round_reg + 4'd1;
                end
            end else begin
                hold_reg <= hold_reg + 2'd1;
            end
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            st_idle:  if (v_i) fsm_next = st_init;
            st_init:  if (capture) fsm_next = st_round;
            st_round: if (capture && (round_reg == 4'(last_round - 1))) fsm_next = st_final;
            st_final: if (capture) fsm_next = st_done;
            st_done:  if (yumi_i) fsm_next = st_idle;
            default:  fsm_next = st_idle;
        endcase
        if (abort_req) begin
            fsm_next = st_idle;
        end
    end

    always_comb begin
        ready_o   = 1'b0;
        v_o       = 1'b0;
        dp_mode_o = mode_idle;
        case (fsm_reg)
            st_idle:  ready_o   = 1'b1;
            st_init:  dp_mode_o = mode_ark;
            st_round: dp_mode_o = mode_round;
            st_final: dp_mode_o = mode_final;
            st_done:  v_o       = 1'b1;
            default:  dp_mode_o = mode_idle;
        endcase
    end

    assign dp_state_o = blk_reg;
    assign dp_key_o   = key_reg;
    assign data_o     = blk_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (1- and 3-cycle hold) with a behavioural
// AES round datapath, known-answer vectors and multi-cycle corner sequences.
module tb_aes_round_sequencer;
    import aes_pkg::*;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         v_drv, yumi_drv, abort_drv;
    logic         sel;
    logic [127:0] data_in, key_in;

    logic         ready1, v1_o, ready3, v3_o;
    logic [127:0] dps1, dpk1, res1, dout1, dps3, dpk3, res3, dout3;
    logic [1:0]   dpm1, dpm3;

    logic         cur_ready, cur_v;
    logic [127:0] cur_state, cur_key, cur_data;
    logic [1:0]   cur_mode;

    int           n_checks, n_pass;
    int           cyc;
    logic [127:0] exp_q[$];
    logic [127:0] r1_state, r1_key;
    vec_t         vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Reference round datapath (column-major state, byte 0 = MSB).
    function automatic logic [127:0] dp_model(input logic [127:0] s, input logic [127:0] k,
                                              input logic [1:0] m);
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [127:0] o;
        if (m == 2'd3) return s;
        if (m == 2'd0) return s ^ k;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r+4*c] = a[r+4*((c+r)%4)];
        if (m == 2'd1) begin
            for (int c = 0; c < 4; c++) begin
                a[0] = b[4*c]; a[1] = b[4*c+1]; a[2] = b[4*c+2]; a[3] = b[4*c+3];
                b[4*c]   = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
                b[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
                b[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
                b[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    assign res1 = dp_model(dps1, dpk1, dpm1);
    assign res3 = dp_model(dps3, dpk3, dpm3);

    aes_round_sequencer #(.round_cycles_p(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .v_i(v_drv & ~sel), .ready_o(ready1),
        .data_i(data_in), .key_i(key_in), .dp_state_o(dps1), .dp_key_o(dpk1),
        .dp_mode_o(dpm1), .dp_result_i(res1), .v_o(v1_o), .data_o(dout1),
`ifdef AES_SEQ_ABORT_EN
        .abort_i(abort_drv),
`endif
        .yumi_i(yumi_drv & ~sel)
    );

    aes_round_sequencer #(.round_cycles_p(3)) dut3 (
        .clk_i(clk), .reset_i(reset), .v_i(v_drv & sel), .ready_o(ready3),
        .data_i(data_in), .key_i(key_in), .dp_state_o(dps3), .dp_key_o(dpk3),
        .dp_mode_o(dpm3), .dp_result_i(res3), .v_o(v3_o), .data_o(dout3),
`ifdef AES_SEQ_ABORT_EN
        .abort_i(abort_drv & sel),
`endif
        .yumi_i(yumi_drv & sel)
    );

    assign cur_ready = sel ? ready3 : ready1;
    assign cur_v     = sel ? v3_o   : v1_o;
    assign cur_state = sel ? dps3   : dps1;
    assign cur_key   = sel ? dpk3   : dpk1;
    assign cur_mode  = sel ? dpm3   : dpm1;
    assign cur_data  = sel ? dout3  : dout1;

    task automatic check(input bit ok, input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Handshake at the next rising edge; afterwards the bench sits in cycle 1.
    task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct);
        @(negedge clk);
        data_in = pt;
        key_in  = k;
        v_drv   = 1'b1;
        @(posedge clk);
        exp_q.push_back(ct);
        #1;
        v_drv   = 1'b0;
        data_in = ~pt;
        key_in  = ~k;
        cyc     = 1;
    endtask

    task automatic wait_done(input int rc, output int lat, output int bad_mode,
                             output int bad_hold);
        logic [257:0] prev;
        logic [1:0]   exp_mode;
        int           w;
        bad_mode = 0;
        bad_hold = 0;
        prev     = '0;
        @(negedge clk);
        while (!cur_v && cyc < 200) begin
            w = (cyc - 1) / rc;
            exp_mode = (w == 0) ? 2'd0 : ((w <= 9) ? 2'd1 : 2'd2);
            if (cur_mode != exp_mode) bad_mode++;
            if (((cyc - 1) % rc != 0) && ({cur_state, cur_key, cur_mode} != prev)) bad_hold++;
            prev = {cur_state, cur_key, cur_mode};
            if (cyc == rc + 1) begin
                r1_state = cur_state;
                r1_key   = cur_key;
            end
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
    endtask

    task automatic pop_compare(input string name);
        logic [127:0] e;
        if (exp_q.size() == 0) begin
            check(1'b0, {name, "_queue_empty"}, cur_data, '0);
        end else begin
            e = exp_q.pop_front();
            check(cur_v && (cur_data == e), name, cur_data, e);
        end
    endtask

    task automatic yumi_and_check_ready(input string name);
        yumi_drv = 1'b1;
        @(posedge clk);
        #1;
        yumi_drv = 1'b0;
        v_drv    = 1'b0;
        @(negedge clk);
        check(cur_ready && !cur_v && cur_mode == 2'd3, name, {cur_ready, cur_v, cur_mode},
              {1'b1, 1'b0, 2'd3});
    endtask

    task automatic full_block(input vec_t v, input int rc, input string tag);
        int lat, bm, bh;
        send(v.pt, v.key, v.ct);
        wait_done(rc, lat, bm, bh);
        $display("block %s pt=%h key=%h data_o=%h latency=%0d", tag, v.pt, v.key, cur_data, lat);
        check(lat == 11 * rc + 1, {tag, "_latency"}, 128'(lat), 128'(11 * rc + 1));
        pop_compare({tag, "_ciphertext"});
        check(bm == 0, {tag, "_mode_seq"}, 128'(bm), 128'd0);
        check(bh == 0, {tag, "_hold_stable"}, 128'(bh), 128'd0);
        yumi_and_check_ready({tag, "_ready_after_yumi"});
    endtask

    initial begin
        int           lat, bm, bh, seen, bad;
        logic [127:0] snap;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h00000000000000000000000000000000, 128'h00000000000000000000000000000000,
                    128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};

        n_checks  = 0;
        n_pass    = 0;
        sel       = 1'b0;
        yumi_drv  = 1'b0;
        abort_drv = 1'b0;
        data_in   = 128'hdeadbeef;
        key_in    = 128'hcafef00d;

        // Reset asserted together with v_i: reset must win.
        reset = 1'b1;
        v_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        v_drv = 1'b0;
        @(negedge clk);
        $display("reset ready=%b v_o=%b mode=%0d data_o=%h", ready1, v1_o, dpm1, dout1);
        check(ready1 && ready3, "reset_ready", {ready1, ready3}, 2'b11);
        check(!v1_o && !v3_o, "reset_v_o", {v1_o, v3_o}, 2'b00);
        check(dpm1 == 2'd3 && dpm3 == 2'd3, "reset_dp_mode", {dpm1, dpm3}, 4'hf);
        check(dout1 == '0 && dout3 == '0, "reset_data_o", dout1 | dout3, '0);
        check(dps1 == '0 && dpk1 == '0, "reset_dp_state_key", dps1 | dpk1, '0);

        for (int i = 0; i < 4; i++) begin
            full_block(vecs[i], 1, $sformatf("vec%0d", i));
            if (i == 0) begin
                check(r1_state == 128'h00102030405060708090a0b0c0d0e0f0, "c1_state_after_init",
                      r1_state, 128'h00102030405060708090a0b0c0d0e0f0);
                check(r1_key == 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "c1_round1_key",
                      r1_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
            end
        end

        sel = 1'b1;
        full_block(vecs[0], 3, "hold3_c1");
        check(r1_key == 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "hold3_round1_key",
              r1_key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        sel = 1'b0;

        // DONE held without yumi: output frozen, new requests ignored.
        send(vecs[1].pt, vecs[1].key, vecs[1].ct);
        wait_done(1, lat, bm, bh);
        pop_compare("done_hold_ciphertext");
        snap = cur_data;
        bad  = 0;
        for (int i = 0; i < 5; i++) begin
            v_drv   = 1'b1;
            data_in = 128'(i + 1);
            @(negedge clk);
            if (!cur_v || cur_ready || cur_data != snap) bad++;
        end
        $display("done_hold cycles=5 bad=%0d data_o=%h", bad, cur_data);
        check(bad == 0, "done_hold_stable", 128'(bad), 128'd0);
        yumi_and_check_ready("no_accept_in_yumi_cycle");

        // Reset during round 5 abandons the block.
        send(vecs[2].pt, vecs[2].key, vecs[2].ct);
        repeat (6) @(negedge clk);
        check(cur_mode == 2'd1, "round5_mode", 128'(cur_mode), 128'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check(cur_ready && cur_mode == 2'd3, "reset_mid_idle", {cur_ready, cur_mode}, 3'b111);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (cur_v) seen++;
        end
        $display("reset_mid v_o_seen=%0d", seen);
        check(seen == 0, "reset_mid_no_v_o", 128'(seen), 128'd0);
        exp_q.delete();
        full_block(vecs[3], 1, "after_reset");

`ifdef AES_SEQ_ABORT_EN
        send(vecs[1].pt, vecs[1].key, vecs[1].ct);
        repeat (4) @(negedge clk);
        abort_drv = 1'b1;
        @(posedge clk);
        #1;
        abort_drv = 1'b0;
        @(negedge clk);
        check(cur_ready && cur_mode == 2'd3, "abort_idle", {cur_ready, cur_mode}, 3'b111);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (cur_v) seen++;
        end
        $display("abort round3 v_o_seen=%0d", seen);
        check(seen == 0, "abort_no_v_o", 128'(seen), 128'd0);
        exp_q.delete();
        send(vecs[0].pt, vecs[0].key, vecs[0].ct);
        wait_done(1, lat, bm, bh);
        snap = vecs[0].ct;
        pop_compare("abort_then_block");
        abort_drv = 1'b1;
        @(posedge clk);
        #1;
        abort_drv = 1'b0;
        @(negedge clk);
        check(cur_v && cur_data == snap, "abort_in_done_ignored", cur_data, snap);
        yumi_and_check_ready("abort_done_ready");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
